// File: rtl/branch_resolve_if.sv
// branch_resolve_if: decode, flag and jump-through-memory bundle around branch_resolve_unit.
interface branch_resolve_if #(
  parameter int ADDR_W = 32,
  parameter int BIMM_W = 16,
  parameter int JIMM_W = 26,
  parameter int CNT_W  = 8
);
  logic              instr_valid;
  logic [2:0]        bj_type;
  logic [ADDR_W-1:0] pc;
  logic [BIMM_W-1:0] bimm;
  logic [JIMM_W-1:0] jimm;
  logic [ADDR_W-1:0] reg_a;
  logic              alu_z;
  logic              alu_n;
  logic              stat_we;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] next_pc;
  logic [1:0]        pc_sel;
  logic              pc_load;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              link_we;
  logic [1:0]        stat_q;
  logic              fault;
  logic [CNT_W-1:0]  taken_cnt;
  modport master (
    output instr_valid, bj_type, pc, bimm, jimm, reg_a, alu_z, alu_n, stat_we, mem_ack, mem_rdata,
    input  next_pc, pc_sel, pc_load, stall, mem_req, mem_addr, link_we, stat_q, fault, taken_cnt
  );
  modport slave (
    input  instr_valid, bj_type, pc, bimm, jimm, reg_a, alu_z, alu_n, stat_we, mem_ack, mem_rdata,
    output next_pc, pc_sel, pc_load, stall, mem_req, mem_addr, link_we, stat_q, fault, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves jumps/branches to next_pc, runs the jump-through-memory
// wait with timeout, holds the {Z,N} status flags and counts redirects.
module branch_resolve_unit #(
  parameter int ADDR_W  = 32,
  parameter int BIMM_W  = 16,
  parameter int JIMM_W  = 26,
  parameter int TMO_CYC = 15,
  parameter int CNT_W   = 8
) (
  input logic clk,
  input logic rst_n,
  branch_resolve_if.slave bus
);
  typedef enum logic {IDLE, JM_WAIT} state_t;
  localparam logic [2:0] BJ_J = 3'b001, BJ_BEQ = 3'b010, BJ_BGEZ = 3'b011, BJ_BRN = 3'b100,
                         BJ_JM = 3'b101, BJ_BALZ = 3'b110, BJ_ILL = 3'b111;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d, taken_q, taken_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        stat_q, stat_d;
  logic              fault_q, fault_d, mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] seq, br, jt, next_pc;
  logic [1:0]        pc_sel;
  logic              pc_load, stall, link_we, ack, tmo_hit;
  assign seq = bus.pc + ADDR_W'(4);
  assign br  = seq + {{(ADDR_W-BIMM_W-2){bus.bimm[BIMM_W-1]}}, bus.bimm, 2'b00};
  assign jt  = {seq[ADDR_W-1:JIMM_W+2], bus.jimm, 2'b00};
  always_comb begin
    ack        = state_q == JM_WAIT && bus.mem_ack;
    tmo_hit    = state_q == JM_WAIT && !bus.mem_ack && tmo_q == TMO_LAST;
    next_pc    = seq;
    pc_sel     = 2'b00;
    pc_load    = 1'b0;
    stall      = 1'b0;
    link_we    = 1'b0;
    state_d    = state_q;
    tmo_d      = tmo_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    fault_d    = 1'b0;
    stat_d     = bus.stat_we ? {bus.alu_z, bus.alu_n} : stat_q;
    if (state_q == IDLE) begin
      pc_load = bus.instr_valid;
      if (bus.instr_valid)
        case (bus.bj_type)
          BJ_J: begin
            pc_sel  = 2'b01;
            next_pc = jt;
          end
          BJ_BEQ: begin
            pc_sel  = bus.alu_z ? 2'b01 : 2'b00;
            next_pc = bus.alu_z ? br : seq;
          end
          BJ_BGEZ: begin
            pc_sel  = !bus.alu_n ? 2'b01 : 2'b00;
            next_pc = !bus.alu_n ? br : seq;
          end
          BJ_BRN: begin
            pc_sel  = stat_q[0] ? 2'b11 : 2'b00;
            next_pc = stat_q[0] ? bus.reg_a : seq;
          end
          BJ_JM: begin
            pc_load    = 1'b0;
            stall      = 1'b1;
            state_d    = JM_WAIT;
            mem_addr_d = bus.reg_a;
            mem_req_d  = 1'b1;
            tmo_d      = '0;
          end
          BJ_BALZ: begin
            pc_sel  = stat_q[1] ? 2'b01 : 2'b00;
            next_pc = stat_q[1] ? br : seq;
            link_we = stat_q[1];
          end
          BJ_ILL:  fault_d = 1'b1;
          default: ;
        endcase
    end else begin
      stall   = !(ack || tmo_hit);
      pc_load = ack || tmo_hit;
      pc_sel  = ack ? 2'b10 : 2'b00;
      next_pc = ack ? (bus.mem_rdata & ~ADDR_W'(3)) : seq;
      tmo_d   = tmo_q + CNT_W'(1);
      fault_d = tmo_hit;
      if (ack || tmo_hit) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    end
    taken_d = (pc_load && pc_sel != 2'b00 && taken_q != '1) ? taken_q + CNT_W'(1) : taken_q;
    // While reset is held the unit behaves as a plain sequential fetcher.
    if (!rst_n) begin
      next_pc = seq;
      pc_sel  = 2'b00;
      pc_load = bus.instr_valid;
      stall   = 1'b0;
      link_we = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      taken_q    <= '0;
      mem_addr_q <= '0;
      stat_q     <= 2'b00;
      fault_q    <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      taken_q    <= taken_d;
      mem_addr_q <= mem_addr_d;
      stat_q     <= stat_d;
      fault_q    <= fault_d;
      mem_req_q  <= mem_req_d;
    end
  end
  assign bus.next_pc   = next_pc;
  assign bus.pc_sel    = pc_sel;
  assign bus.pc_load   = pc_load;
  assign bus.stall     = stall;
  assign bus.link_we   = link_we;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.stat_q    = stat_q;
  assign bus.fault     = fault_q;
  assign bus.taken_cnt = taken_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random checks of branch_resolve_unit against an
// instruction-level model of redirects, flags, jm waits and the redirect counter.
module tb_branch_resolve_unit;
  localparam int TMO = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [1:0]  m_stat;
  int          m_cnt;
  bit          m_wait;
  int          m_tmo;
  logic [31:0] m_addr;
  bit          m_fault;
  branch_resolve_if bus ();
  branch_resolve_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_stat = 2'b00; m_cnt = 0; m_wait = 0; m_tmo = 0; m_addr = 32'h0; m_fault = 0;
  endtask
  task automatic step(input bit iv, input logic [2:0] bj, input logic [31:0] p, input logic [15:0] b,
                      input logic [25:0] j, input logic [31:0] ra, input bit z, input bit n,
                      input bit we, input bit ack, input logic [31:0] rd);
    logic [31:0] seq, br, jt, e_pc;
    logic [1:0]  e_sel;
    bit e_load, e_stall, e_link, e_fault;
    bus.instr_valid = iv; bus.bj_type = bj; bus.pc = p; bus.bimm = b; bus.jimm = j;
    bus.reg_a = ra; bus.alu_z = z; bus.alu_n = n; bus.stat_we = we; bus.mem_ack = ack; bus.mem_rdata = rd;
    #2;
    seq = p + 32'd4;
    br  = seq + 32'(int'($signed(b)) * 4);
    jt  = (seq & 32'hF000_0000) | (32'(j) << 2);
    e_pc = seq; e_sel = 2'b00; e_load = 0; e_stall = 0; e_link = 0; e_fault = 0;
    if (m_wait) begin
      if (ack) begin e_load = 1; e_sel = 2'b10; e_pc = rd & 32'hFFFF_FFFC; end
      else if (m_tmo == TMO - 1) begin e_load = 1; e_fault = 1; end
      else e_stall = 1;
    end else if (iv) begin
      e_load = 1;
      case (bj)
        3'd1: begin e_sel = 2'b01; e_pc = jt; end
        3'd2: if (z) begin e_sel = 2'b01; e_pc = br; end
        3'd3: if (!n) begin e_sel = 2'b01; e_pc = br; end
        3'd4: if (m_stat[0]) begin e_sel = 2'b11; e_pc = ra; end
        3'd5: begin e_load = 0; e_stall = 1; end
        3'd6: if (m_stat[1]) begin e_sel = 2'b01; e_pc = br; e_link = 1; end
        3'd7: e_fault = 1;
        default: ;
      endcase
    end
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("pc_load", 32'(bus.pc_load), 32'(e_load));
    chk("link_we", 32'(bus.link_we), 32'(e_link));
    chk("mem_req", 32'(bus.mem_req), 32'(m_wait));
    chk("stat_q", 32'(bus.stat_q), 32'(m_stat));
    chk("fault", 32'(bus.fault), 32'(m_fault));
    chk("taken_cnt", 32'(bus.taken_cnt), 32'(m_cnt));
    if (m_wait) chk("mem_addr", bus.mem_addr, m_addr);
    if (e_load) begin
      chk("next_pc", bus.next_pc, e_pc);
      chk("pc_sel", 32'(bus.pc_sel), 32'(e_sel));
    end
    @(posedge clk);
    #1;
    if (we) m_stat = {z, n};
    m_fault = e_fault;
    if (e_load && e_sel != 2'b00 && m_cnt < 255) m_cnt++;
    if (!m_wait) begin
      if (iv && bj == 3'd5) begin m_wait = 1; m_tmo = 0; m_addr = ra; end
    end else if (e_load) m_wait = 0;
    else m_tmo++;
  endtask
  initial begin
    model_reset();
    bus.instr_valid = 1; bus.bj_type = 3'd1; bus.pc = 32'h100; bus.bimm = 0; bus.jimm = 26'h5;
    bus.reg_a = 0; bus.alu_z = 0; bus.alu_n = 0; bus.stat_we = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
    #2;
    chk("rst_pc_load", 32'(bus.pc_load), 32'd1);
    chk("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
    chk("rst_next_pc", bus.next_pc, 32'h104);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_stat", 32'(bus.stat_q), 32'd0);
    chk("rst_taken", 32'(bus.taken_cnt), 32'd0);
    @(negedge clk);
    bus.instr_valid = 0;
    rst_n = 1;
    @(posedge clk);
    #1;
    step(1, 3'd2, 32'h100, 16'hFFFF, 0, 0, 1, 0, 0, 0, 0);
    step(1, 3'd2, 32'h100, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3'd4, 32'h300, 0, 0, 32'h2000, 0, 1, 1, 0, 0);
    step(1, 3'd4, 32'h300, 0, 0, 32'h2000, 0, 0, 0, 0, 0);
    step(1, 3'd5, 32'h400, 0, 0, 32'h40, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 3'd1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 32'h8003);
    step(1, 3'd1, 32'h400, 0, 0, 0, 0, 0, 0, 1, 32'h8003);
    step(1, 3'd5, 32'h500, 0, 0, 32'h80, 0, 0, 0, 0, 0);
    for (int i = 0; i < TMO; i++) step(1, 3'd0, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 3'd0, 32'h504, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3'd0, 32'h600, 0, 0, 0, 1, 0, 1, 0, 0);
    step(1, 3'd6, 32'h200, 16'd4, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3'd7, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3'd0, 32'h204, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, 16'($urandom), 26'($urandom),
           $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom);
    for (int i = 0; i < 300; i++) step(1, 3'd1, $urandom, 0, 26'($urandom), 0, 0, 0, 0, 0, 0);
    chk("taken_sat", 32'(bus.taken_cnt), 32'd255);
    step(1, 3'd0, 32'h700, 0, 0, 0, 1, 1, 1, 0, 0);
    step(1, 3'd5, 32'h700, 0, 0, 32'h90, 0, 0, 0, 0, 0);
    step(1, 3'd0, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 0;
    #1;
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_stall", 32'(bus.stall), 32'd0);
    chk("abort_stat", 32'(bus.stat_q), 32'd0);
    chk("abort_taken", 32'(bus.taken_cnt), 32'd0);
    @(negedge clk);
    bus.instr_valid = 0;
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 3'd1, 32'h800, 0, 26'h10, 0, 0, 0, 0, 0, 0);
    step(0, 3'd0, 32'h800, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
